noise_window_sequencer: RTL and testbench

NOISE_WINDOW_SEQUENCER -- requirements
Module: noise_window_sequencer

---
 rtl/noise_window_sequencer_pkg.sv | 26 ++
 rtl/noise_window_sequencer_sync_edge_detect.sv | 37 +++
 rtl/noise_window_sequencer.sv | 128 ++++++++++++
 tb/tb_noise_window_sequencer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/noise_window_sequencer_pkg.sv
// Shared widths, state encoding and window-length helper for the noise window sequencer.
package noise_window_sequencer_pkg;

    localparam int DATA_W       = 14;
    localparam int NOISE_W      = 16;
    localparam int ACC_W        = 25;
    localparam int MIN_WIN_LOG2 = 4;
    localparam int PAUSE_W      = 13;
    localparam int WSEL_W       = 3;
    localparam int CNT_W        = 13;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PAUSE = 2'd1,
        ST_ACCUM = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Index of the final sample in a window of 2^(sel+MIN_WIN_LOG2) samples.
    function automatic logic [CNT_W-1:0] win_last(input logic [WSEL_W-1:0] sel);
        logic [CNT_W-1:0] w;
        w = CNT_W'(1) << (int'(sel) + MIN_WIN_LOG2);
        return w - CNT_W'(1);
    endfunction

endpackage

// File: rtl/noise_window_sequencer_sync_edge_detect.sv
// Three-flop synchronizer for the measurement-sync pulse with a one-clock rising-edge event.
module sync_edge_detect (
    input  logic ClkFromADC,
    input  logic Reset,
    input  logic async_i,
    output logic level_o,
    output logic rise_o
);

    logic s1_q, s2_q, s3_q;
    logic v1_q, v2_q;
    logic armed_q;

    // armed_q blocks the edge until s2 has carried a genuine low sample, so a
    // sync already high when Reset releases cannot masquerade as a new edge.
    always_ff @(posedge ClkFromADC) begin
        if (Reset) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            s3_q    <= 1'b0;
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            s1_q    <= async_i;
            s2_q    <= s1_q;
            s3_q    <= s2_q;
            v1_q    <= 1'b1;
            v2_q    <= v1_q;
            armed_q <= armed_q | (v2_q & ~s2_q);
        end
    end

    assign level_o = s2_q;
    assign rise_o  = s2_q & ~s3_q & armed_q;

endmodule

// File: rtl/noise_window_sequencer.sv
// Sync-triggered noise measurement: wait PauseLen clocks, average a 2^n sample window, publish mean x4.
module noise_window_sequencer
    import noise_window_sequencer_pkg::*;
(
    input  logic                      ClkFromADC,
    input  logic                      Reset,
    input  logic                      SynchrM,
    input  logic signed [DATA_W-1:0]  DataADC,
    input  logic [PAUSE_W-1:0]        PauseLen,
    input  logic [WSEL_W-1:0]         WinSel,
    output logic signed [NOISE_W-1:0] Noise,
    output logic                      NoiseValid,
    output logic                      Busy,
    output logic                      Overrun
);

    logic sync_rise;
    logic sync_level_unused;

    sync_edge_detect u_sync (
        .ClkFromADC (ClkFromADC),
        .Reset      (Reset),
        .async_i    (SynchrM),
        .level_o    (sync_level_unused),
        .rise_o     (sync_rise)
    );

    // Mean x4 equals sum / 2^(sel+MIN_WIN_LOG2-2); the result always fits NOISE_W.
    function automatic logic signed [NOISE_W-1:0] scale_mean(
        input logic signed [ACC_W-1:0] acc,
        input logic [WSEL_W-1:0]       sel
    );
        logic signed [ACC_W-1:0] sh;
        sh = acc >>> ({1'b0, sel} + 4'd2);
        return sh[NOISE_W-1:0];
    endfunction

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic signed [NOISE_W-1:0] noise_q, noise_d;
    logic                      ovr_q, ovr_d;
    logic [PAUSE_W-1:0]        pause_q, pause_d;
    logic [WSEL_W-1:0]         wsel_q, wsel_d;

    logic signed [ACC_W-1:0]   sample_ext;
    logic signed [ACC_W-1:0]   acc_sum;

    assign sample_ext = {{(ACC_W-DATA_W){DataADC[DATA_W-1]}}, DataADC};
    assign acc_sum    = acc_q + sample_ext;

    always_ff @(posedge ClkFromADC) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            noise_q <= '0;
            ovr_q   <= 1'b0;
            pause_q <= '0;
            wsel_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            noise_q <= noise_d;
            ovr_q   <= ovr_d;
            pause_q <= pause_d;
            wsel_q  <= wsel_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        noise_d = noise_q;
        ovr_d   = ovr_q;
        pause_d = pause_q;
        wsel_d  = wsel_q;
        // A sync edge restarts from any state; DONE still publishes since Noise is already loaded.
        if (sync_rise) begin
            pause_d = PauseLen;
            wsel_d  = WinSel;
            cnt_d   = '0;
            acc_d   = '0;
            state_d = (PauseLen != '0) ? ST_PAUSE : ST_ACCUM;
            if (state_q == ST_PAUSE || state_q == ST_ACCUM) begin
                ovr_d = 1'b1;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_PAUSE: begin
                    if (cnt_q == pause_q - PAUSE_W'(1)) begin
                        cnt_d   = '0;
                        state_d = ST_ACCUM;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_ACCUM: begin
                    acc_d = acc_sum;
                    if (cnt_q == win_last(wsel_q)) begin
                        cnt_d   = '0;
                        noise_d = scale_mean(acc_sum, wsel_q);
                        state_d = ST_DONE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign Noise      = noise_q;
    assign NoiseValid = (state_q == ST_DONE);
    assign Busy       = (state_q == ST_PAUSE) || (state_q == ST_ACCUM);
    assign Overrun    = ovr_q;

endmodule

// File: tb/tb_noise_window_sequencer.sv
// Scoreboard bench for noise_window_sequencer: stimulus queues expected windows, a monitor checks every clock.
module tb_noise_window_sequencer;

    logic               clk = 1'b0;
    logic               Reset;
    logic               SynchrM;
    logic signed [13:0] DataADC;
    logic [12:0]        PauseLen;
    logic [2:0]         WinSel;
    logic signed [15:0] Noise;
    logic               NoiseValid;
    logic               Busy;
    logic               Overrun;

    always #5 clk = ~clk;

    noise_window_sequencer dut (
        .ClkFromADC (clk),
        .Reset      (Reset),
        .SynchrM    (SynchrM),
        .DataADC    (DataADC),
        .PauseLen   (PauseLen),
        .WinSel     (WinSel),
        .Noise      (Noise),
        .NoiseValid (NoiseValid),
        .Busy       (Busy),
        .Overrun    (Overrun)
    );

    typedef struct {
        int due;
        int s0;
        int w;
        bit has_c;
        int cval;
    } exp_t;

    exp_t               sb[$];
    int                 n_chk = 0;
    int                 n_fail = 0;
    int                 cyc = 0;
    logic signed [13:0] hist [0:65535];
    int                 mode = 0;
    int                 cval_d = 0;
    int                 ramp_base = 0;
    bit                 exp_ovr = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Mean of the window times four, rounded toward minus infinity.
    function automatic longint model_noise(input int s0, input int w);
        longint sum = 0;
        longint num;
        longint q;
        for (int k = s0; k < s0 + w; k++) sum += hist[k];
        num = sum * 4;
        q = num / w;
        if ((num % w != 0) && (num < 0)) q = q - 1;
        return q;
    endfunction

    initial begin : monitor
        longint last_noise = 0;
        longint ev;
        exp_t   e;
        forever begin
            @(posedge clk);
            #1;
            if (Reset) begin
                check("valid_in_reset", NoiseValid, 0);
                last_noise = 0;
            end else if (NoiseValid) begin
                if (sb.size() == 0 || sb[0].due != cyc) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_valid: NoiseValid=1 at cycle %0d, required 0", cyc);
                    last_noise = Noise;
                end else begin
                    e = sb[0];
                    sb.delete(0);
                    ev = e.has_c ? longint'(e.cval) : model_noise(e.s0, e.w);
                    check("noise_value", Noise, ev);
                    last_noise = ev;
                end
            end else begin
                if (sb.size() != 0 && sb[0].due <= cyc) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL missed_valid: NoiseValid=0 at cycle %0d, required 1 at cycle %0d", cyc, sb[0].due);
                    sb.delete(0);
                end
                check("noise_hold", Noise, last_noise);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        case (mode)
            1:       DataADC = 14'(cval_d);
            2:       DataADC = 14'((cyc - ramp_base) & 15);
            default: DataADC = 14'($urandom);
        endcase
        hist[cyc] = DataADC;
    endtask

    task automatic fire(input int p, input int ws, input bit hc, input int cv);
        int   c;
        int   e;
        exp_t x;
        PauseLen = 13'(p);
        WinSel   = 3'(ws);
        SynchrM  = 1'b1;
        c = cyc;
        e = c + 2;
        if (sb.size() != 0 && sb[sb.size()-1].due > e) begin
            sb.delete(sb.size() - 1);
            exp_ovr = 1'b1;
        end
        x.w     = 16 << ws;
        x.s0    = c + 3 + p;
        x.due   = x.s0 + x.w;
        x.has_c = hc;
        x.cval  = cv;
        sb.push_back(x);
        if (mode == 2) ramp_base = x.s0;
        repeat (3) tick();
        SynchrM  = 1'b0;
        PauseLen = 13'($urandom);
        WinSel   = 3'($urandom);
        check("busy_after_sync", Busy, 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (sb.size() != 0 && n < 20000) begin
            tick();
            n++;
        end
        if (sb.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL idle_timeout: %0d windows outstanding, required 0", sb.size());
            sb.delete();
        end
        repeat (2) tick();
        check("busy_idle", Busy, 0);
    endtask

    initial begin : watchdog
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int d;
        int s0;
        Reset    = 1'b1;
        SynchrM  = 1'b0;
        DataADC  = '0;
        PauseLen = '0;
        WinSel   = '0;
        repeat (4) tick();
        check("reset_noise", Noise, 0);
        check("reset_valid", NoiseValid, 0);
        check("reset_busy", Busy, 0);
        check("reset_overrun", Overrun, 0);
        Reset = 1'b0;
        repeat (4) tick();

        mode = 1; cval_d = 100;
        fire(8000, 3, 1'b1, 400);
        wait_idle();

        mode = 1; cval_d = -8192;
        fire(0, 7, 1'b1, -32768);
        wait_idle();

        mode = 2;
        fire(10, 0, 1'b1, 30);
        wait_idle();

        // Sync edge landing exactly on the DONE clock.
        mode = 0;
        fire(2, 0, 1'b0, 0);
        d = sb[sb.size()-1].due;
        while (cyc < d - 2) tick();
        fire(3, 1, 1'b0, 0);
        check("overrun_done_sync", Overrun, 0);
        wait_idle();
        check("overrun_after_done", Overrun, 0);

        for (int i = 0; i < 12; i++) begin
            fire($urandom_range(0, 40), $urandom_range(0, 2), 1'b0, 0);
            check("overrun_random", Overrun, exp_ovr);
            repeat ($urandom_range(3, 70)) tick();
        end
        wait_idle();
        check("overrun_random_end", Overrun, exp_ovr);

        // Second sync at ACCUM sample 5 aborts the first window.
        fire(4, 1, 1'b0, 0);
        s0 = sb[sb.size()-1].s0;
        while (cyc < s0 + 3) tick();
        fire(5, 0, 1'b0, 0);
        check("overrun_abort", Overrun, 1);
        wait_idle();

        // Reset in ACCUM with SynchrM held high.
        fire(0, 2, 1'b0, 0);
        repeat (5) tick();
        SynchrM = 1'b1;
        Reset   = 1'b1;
        sb.delete();
        exp_ovr = 1'b0;
        repeat (3) tick();
        check("rst_mid_noise", Noise, 0);
        check("rst_mid_valid", NoiseValid, 0);
        check("rst_mid_busy", Busy, 0);
        check("rst_mid_overrun", Overrun, 0);
        Reset = 1'b0;
        repeat (20) tick();
        check("held_sync_no_edge", Busy, 0);
        SynchrM = 1'b0;
        repeat (4) tick();
        fire(3, 0, 1'b0, 0);
        wait_idle();
        check("overrun_after_reset", Overrun, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
